// File: rtl/assoc_pkg.sv
// Shared constants and FSM state type for the associative-memory stage.
package assoc_pkg;

  localparam int NUM_CLASSES = 26;
  localparam int SCORE_W     = 13;
  localparam int CLASS_W     = 5;

  localparam logic [CLASS_W-1:0] LAST_ADDR = CLASS_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } assoc_state_e;

endpackage

// File: rtl/assoc_running_max.sv
// Compare-and-hold register pair: keeps the highest score seen since the
// last clear together with the class that produced it. Strict greater-than
// means an earlier (lower-index) class keeps the lead on a tie.
module assoc_running_max #(
  parameter int SCORE_W = 13,
  parameter int CLASS_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [SCORE_W-1:0] in_score,
  input  logic [CLASS_W-1:0] in_class,
  output logic [SCORE_W-1:0] best_score,
  output logic [CLASS_W-1:0] best_class,
  output logic               best_valid
);

  logic [SCORE_W-1:0] best_score_q, best_score_d;
  logic [CLASS_W-1:0] best_class_q, best_class_d;
  logic               best_valid_q, best_valid_d;

  function automatic logic takes_lead(input logic               have_best,
                                      input logic [SCORE_W-1:0] cand,
                                      input logic [SCORE_W-1:0] best);
    return !have_best || (cand > best);
  endfunction

  // Next-state: clear wins, otherwise a tagged beat replaces the holder if it leads
  always_comb begin
    best_score_d = best_score_q;
    best_class_d = best_class_q;
    best_valid_d = best_valid_q;
    if (clear) begin
      best_score_d = '0;
      best_class_d = '0;
      best_valid_d = 1'b0;
    end else if (in_valid && takes_lead(best_valid_q, in_score, best_score_q)) begin
      best_score_d = in_score;
      best_class_d = in_class;
      best_valid_d = 1'b1;
    end
  end

  // Holder registers
  always_ff @(posedge clk) begin
    if (rst) begin
      best_score_q <= '0;
      best_class_q <= '0;
      best_valid_q <= 1'b0;
    end else begin
      best_score_q <= best_score_d;
      best_class_q <= best_class_d;
      best_valid_q <= best_valid_d;
    end
  end

  assign best_score = best_score_q;
  assign best_class = best_class_q;
  assign best_valid = best_valid_q;

endmodule

// File: rtl/assoc_argmax_seq.sv
// Sequential argmax: scans the class-score bank one class per cycle, keeps a
// running maximum and offers the winner on a valid/ready output.
module assoc_argmax_seq #(
  parameter int NUM_CLASSES = 26,
  parameter int SCORE_W     = 13,
  parameter int CLASS_W     = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               score_rd_en,
  output logic [CLASS_W-1:0] score_addr,
  input  logic [SCORE_W-1:0] score_rdata,
  output logic               inf_valid,
  input  logic               inf_ready,
  output logic [CLASS_W-1:0] inference,
  output logic [SCORE_W-1:0] inf_score
);

  import assoc_pkg::*;

  localparam logic [CLASS_W-1:0] LAST_IDX = CLASS_W'(NUM_CLASSES - 1);

  assoc_state_e       state_q, state_d;
  logic [CLASS_W-1:0] addr_q, addr_d;
  logic               rd_q, rd_d;
  logic [CLASS_W-1:0] addr_tag_q, addr_tag_d;
  logic [CLASS_W-1:0] res_class_q, res_class_d;
  logic [SCORE_W-1:0] res_score_q, res_score_d;
  logic               clear_best;

  logic [SCORE_W-1:0] best_score;
  logic [CLASS_W-1:0] best_class;
  logic               best_valid;

  // FSM next-state, address counter and result capture on handshake
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    res_class_d = res_class_q;
    res_score_d = res_score_q;
    clear_best  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FETCH;
          addr_d     = '0;
          clear_best = 1'b1;
        end
      end
      FETCH: begin
        if (addr_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + CLASS_W'(1);
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        if (inf_ready) begin
          state_d     = IDLE;
          res_class_d = best_class;
          res_score_d = best_score;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read tag travels one cycle behind the read strobe to label the data beat
  always_comb begin
    rd_d       = score_rd_en;
    addr_tag_d = addr_q;
  end

  // State, counter, read tag and held-result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      addr_tag_q  <= '0;
      res_class_q <= '0;
      res_score_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      addr_tag_q  <= addr_tag_d;
      res_class_q <= res_class_d;
      res_score_q <= res_score_d;
    end
  end

  assoc_running_max #(
    .SCORE_W (SCORE_W),
    .CLASS_W (CLASS_W)
  ) u_running_max (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear_best),
    .in_valid   (rd_q),
    .in_score   (score_rdata),
    .in_class   (addr_tag_q),
    .best_score (best_score),
    .best_class (best_class),
    .best_valid (best_valid)
  );

  // In DONE the holder is final and shown directly; elsewhere the last
  // accepted result stays visible so it can still be read after the handshake.
  always_comb begin
    busy        = (state_q != IDLE);
    score_rd_en = (state_q == FETCH);
    score_addr  = (state_q == FETCH) ? addr_q : '0;
    inf_valid   = (state_q == DONE);
    inference   = (state_q == DONE) ? best_class : res_class_q;
    inf_score   = (state_q == DONE) ? best_score : res_score_q;
  end

  logic unused_best_valid;
  assign unused_best_valid = best_valid;

endmodule

// File: tb/tb_assoc_argmax_seq.sv
// Directed testbench for assoc_argmax_seq with a one-cycle-latency score bank.
module tb_assoc_argmax_seq;

  localparam int NC = 26;
  localparam int SW = 13;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy;
  logic          score_rd_en;
  logic [CW-1:0] score_addr;
  logic [SW-1:0] score_rdata = '0;
  logic          inf_valid;
  logic          inf_ready = 1'b0;
  logic [CW-1:0] inference;
  logic [SW-1:0] inf_score;

  logic [SW-1:0] bank [0:31];
  int            rd_count = 0;
  int            addr_err = 0;
  logic          rd_prev = 1'b0;
  int            last_addr = 0;

  int n_checks = 0;
  int n_fail   = 0;

  assoc_argmax_seq #(.NUM_CLASSES(NC), .SCORE_W(SW), .CLASS_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .score_rd_en (score_rd_en),
    .score_addr  (score_addr),
    .score_rdata (score_rdata),
    .inf_valid   (inf_valid),
    .inf_ready   (inf_ready),
    .inference   (inference),
    .inf_score   (inf_score)
  );

  always #5 clk = ~clk;

  // Score bank: data returned one cycle after the read strobe
  always @(posedge clk) begin
    if (score_rd_en) score_rdata <= bank[score_addr];
  end

  // Read monitor: counts reads and flags any non-ascending or out-of-range address
  always @(posedge clk) begin
    if (score_rd_en) begin
      rd_count++;
      if (!rd_prev) begin
        if (score_addr != 0) addr_err++;
      end else if (int'(score_addr) != last_addr + 1) begin
        addr_err++;
      end
      if (int'(score_addr) > NC - 1) addr_err++;
      last_addr = int'(score_addr);
    end
    rd_prev = score_rd_en;
  end

  task automatic fill(input int base, input int step);
    for (int i = 0; i < 32; i++) bank[i] = SW'(base + step * i);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input int lat0, output int lat);
    lat = lat0;
    while (!inf_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; inf_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0d expected 0", busy); end
    n_checks++; if (score_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %0d expected 0", score_rd_en); end
    n_checks++; if (score_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", score_addr); end
    n_checks++; if (inf_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0d expected 0", inf_valid); end
    n_checks++; if (inference !== '0) begin n_fail++; $display("FAIL reset_inference: got %0d expected 0", inference); end
    n_checks++; if (inf_score !== '0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", inf_score); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Scores equal to class index: winner is the last class, 28-cycle latency
  task automatic test_ramp();
    int lat;
    inf_ready = 1'b1;
    fill(0, 1);
    pulse_start();
    wait_valid(1, lat);
    n_checks++; if (lat !== 28) begin n_fail++; $display("FAIL ramp_latency: got %0d expected 28", lat); end
    n_checks++; if (inference !== 5'd25) begin n_fail++; $display("FAIL ramp_inference: got %0d expected 25", inference); end
    n_checks++; if (inf_score !== 13'd25) begin n_fail++; $display("FAIL ramp_score: got %0d expected 25", inf_score); end
    @(posedge clk); #1;
    n_checks++; if (inf_valid !== 1'b0) begin n_fail++; $display("FAIL ramp_valid_drop: got %0d expected 0", inf_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ramp_busy_drop: got %0d expected 0", busy); end
    n_checks++; if (inference !== 5'd25) begin n_fail++; $display("FAIL ramp_hold_idle: got %0d expected 25", inference); end
  endtask

  // Full-scale values at each end of the scan
  task automatic test_extremes();
    int lat;
    fill(100, 0); bank[25] = 13'd8191;
    pulse_start(); wait_valid(1, lat);
    n_checks++; if (inference !== 5'd25) begin n_fail++; $display("FAIL max_last_inference: got %0d expected 25", inference); end
    n_checks++; if (inf_score !== 13'd8191) begin n_fail++; $display("FAIL max_last_score: got %0d expected 8191", inf_score); end
    @(posedge clk); #1;
    fill(8190, 0); bank[0] = 13'd8191;
    pulse_start(); wait_valid(1, lat);
    n_checks++; if (inference !== 5'd0) begin n_fail++; $display("FAIL max_first_inference: got %0d expected 0", inference); end
    n_checks++; if (inf_score !== 13'd8191) begin n_fail++; $display("FAIL max_first_score: got %0d expected 8191", inf_score); end
    @(posedge clk); #1;
  endtask

  // Equal maxima resolve to the lowest index
  task automatic test_ties();
    int lat;
    fill(4999, -1); bank[3] = 13'd5000; bank[17] = 13'd5000;
    pulse_start(); wait_valid(1, lat);
    n_checks++; if (inference !== 5'd3) begin n_fail++; $display("FAIL tie_inference: got %0d expected 3", inference); end
    n_checks++; if (inf_score !== 13'd5000) begin n_fail++; $display("FAIL tie_score: got %0d expected 5000", inf_score); end
    @(posedge clk); #1;
    fill(0, 0);
    pulse_start(); wait_valid(1, lat);
    n_checks++; if (inference !== 5'd0) begin n_fail++; $display("FAIL zeros_inference: got %0d expected 0", inference); end
    n_checks++; if (inf_score !== 13'd0) begin n_fail++; $display("FAIL zeros_score: got %0d expected 0", inf_score); end
    @(posedge clk); #1;
  endtask

  // Result held stable while the consumer stalls
  task automatic test_backpressure();
    int lat;
    inf_ready = 1'b0;
    fill(10, 0); bank[7] = 13'd1234;
    pulse_start(); wait_valid(1, lat);
    for (int c = 0; c < 10; c++) begin
      n_checks++; if (inf_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid c%0d: got %0d expected 1", c, inf_valid); end
      n_checks++; if (inference !== 5'd7) begin n_fail++; $display("FAIL bp_inference c%0d: got %0d expected 7", c, inference); end
      n_checks++; if (inf_score !== 13'd1234) begin n_fail++; $display("FAIL bp_score c%0d: got %0d expected 1234", c, inf_score); end
      @(posedge clk); #1;
    end
    inf_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (inf_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %0d expected 0", inf_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_release_busy: got %0d expected 0", busy); end
  endtask

  // A second start during the scan is ignored
  task automatic test_restart();
    int lat, rd0, ae0;
    fill(1, 1);
    rd0 = rd_count; ae0 = addr_err;
    pulse_start();
    lat = 1;
    repeat (4) begin @(posedge clk); #1; lat++; end
    start = 1'b1;
    @(posedge clk); #1; lat++;
    start = 1'b0;
    wait_valid(lat, lat);
    n_checks++; if (lat !== 28) begin n_fail++; $display("FAIL restart_latency: got %0d expected 28", lat); end
    n_checks++; if (rd_count - rd0 !== 26) begin n_fail++; $display("FAIL restart_reads: got %0d expected 26", rd_count - rd0); end
    n_checks++; if (addr_err - ae0 !== 0) begin n_fail++; $display("FAIL restart_addr_seq: got %0d errors expected 0", addr_err - ae0); end
    n_checks++; if (inf_score !== 13'd26) begin n_fail++; $display("FAIL restart_score: got %0d expected 26", inf_score); end
    @(posedge clk); #1;
  endtask

  // start and ready held high: one result every NUM_CLASSES+3 cycles
  task automatic test_back_to_back();
    int lat, gap;
    fill(0, 1);
    inf_ready = 1'b1;
    start = 1'b1;
    wait_valid(0, lat);
    n_checks++; if (lat >= 200) begin n_fail++; $display("FAIL b2b_first: got timeout expected valid"); end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      wait_valid(1, gap);
      n_checks++; if (gap !== 29) begin n_fail++; $display("FAIL b2b_gap%0d: got %0d expected 29", k, gap); end
      n_checks++; if (inference !== 5'd25) begin n_fail++; $display("FAIL b2b_inference%0d: got %0d expected 25", k, inference); end
    end
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Reset mid-scan aborts; a fresh scan ignores the aborted data
  task automatic test_abort();
    int lat;
    fill(50, 0); bank[2] = 13'd8000;
    pulse_start();
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %0d expected 0", busy); end
    n_checks++; if (score_rd_en !== 1'b0) begin n_fail++; $display("FAIL abort_rd_en: got %0d expected 0", score_rd_en); end
    n_checks++; if (score_addr !== '0) begin n_fail++; $display("FAIL abort_addr: got %0d expected 0", score_addr); end
    n_checks++; if (inf_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %0d expected 0", inf_valid); end
    n_checks++; if (inference !== '0) begin n_fail++; $display("FAIL abort_inference: got %0d expected 0", inference); end
    n_checks++; if (inf_score !== '0) begin n_fail++; $display("FAIL abort_score: got %0d expected 0", inf_score); end
    rst = 1'b0;
    fill(0, 10); bank[10] = 13'd600;
    pulse_start(); wait_valid(1, lat);
    n_checks++; if (lat !== 28) begin n_fail++; $display("FAIL abort_rescan_latency: got %0d expected 28", lat); end
    n_checks++; if (inference !== 5'd10) begin n_fail++; $display("FAIL abort_rescan_inference: got %0d expected 10", inference); end
    n_checks++; if (inf_score !== 13'd600) begin n_fail++; $display("FAIL abort_rescan_score: got %0d expected 600", inf_score); end
    @(posedge clk); #1;
  endtask

  initial begin
    fill(0, 0);
    test_reset();
    test_ramp();
    test_extremes();
    test_ties();
    test_backpressure();
    test_restart();
    test_back_to_back();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/assoc_argmax_seq.md
Name: assoc_argmax_seq

Overview:
Sequential argmax controller for the associative-memory stage. On `start` it walks the class-score bank one class per cycle and keeps a running maximum. It then presents the winning class index and score on a valid/ready output. It is the low-area alternative to the 26-input combinational comparator tree and has identical tie semantics: among equal maxima, the lowest class index wins.

Parameters:
NUM_CLASSES, 26, number of class scores scanned (2..32)
SCORE_W, 13, score width from accumulator bank (unsigned)
CLASS_W, 5, class index width; must satisfy 2**CLASS_W >= NUM_CLASSES

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous active-high reset
start  in  1  pulse/level; sampled only in IDLE, begins a scan
busy  out  1  high in FETCH, DRAIN, DONE
score_rd_en  out  1  read strobe to score bank
score_addr  out  CLASS_W  class index being read
score_rdata  in  SCORE_W  bank data, valid exactly 1 cycle after score_rd_en
inf_valid  out  1  result available
inf_ready  in  1  consumer accepts result
inference  out  CLASS_W  winning class index
inf_score  out  SCORE_W  winning score

Behaviour:
- Reset: one clock, synchronous active-high; `rst` sampled at the rising edge of `clk` and overrides every other input. All outputs reset to 0: busy, score_rd_en, score_addr, inf_valid, inference, inf_score. State goes to IDLE and internal counters/registers clear.
- States:
  - IDLE: busy=0. When `start`=1, go to FETCH; addr counter=0; best_valid=0.
  - FETCH: score_rd_en=1, score_addr=counter.
    - Counter increments each cycle.
    - After issuing NUM_CLASSES-1, go to DRAIN.
  - DRAIN: one cycle, no read issued; the final data beat is compared.
  - DONE: inf_valid=1, inference/inf_score stable.
    - On inf_valid && inf_ready, go to IDLE the next cycle.
    - inf_valid drops in that same transition.
- Compare pipeline:
  - A delayed copy of rd_en/addr (rd_q, addr_q) tags each data beat.
  - When rd_q=1:
    - If best_valid==0 or score_rdata > best_score (strict), then best_score<=score_rdata, best_class<=addr_q, best_valid<=1.
    - Strict `>` with ascending scan gives the lowest-index-wins tie rule.
- Outputs: inference/inf_score are driven from best_class/best_score registers and are updated only on entry to DONE. They hold their value through IDLE until the next DONE, so the last result stays readable.
- Latency: start sampled high in IDLE at edge T0.
  - Reads issue on cycles T0+1..T0+NUM_CLASSES.
  - DRAIN is at T0+NUM_CLASSES+1.
  - inf_valid rises at T0+NUM_CLASSES+2 (28 cycles for default).
  - Throughput: one scan per NUM_CLASSES+3 cycles with inf_ready tied high.
- Boundary conditions:
  - `start` while busy: ignored, with no restart and no queueing.
  - `start` held high across DONE→IDLE: a new scan begins on the first IDLE cycle.
  - inf_ready low: DONE holds indefinitely and outputs stay stable (AXI-style; valid must not drop without ready).
  - inf_ready high before inf_valid: no effect.
  - All scores equal (including all 0): inference=0.
  - Address counter never exceeds NUM_CLASSES-1 and does not wrap.
  - `rst` during FETCH/DRAIN/DONE: the scan aborts and the in-flight read data is discarded. The next cycle is IDLE with all outputs 0.
- Arithmetic: unsigned compare over SCORE_W bits only; no overflow paths.

Decomposition:
- Shared package `assoc_pkg`:
  - Constants NUM_CLASSES, SCORE_W, CLASS_W.
  - State enum {IDLE, FETCH, DRAIN, DONE}.
  - Localparam LAST_ADDR = NUM_CLASSES-1.
  - These are shared with the accumulator and comparator-tree blocks.
- One sub-module, `assoc_running_max`, holds the compare-and-hold register pair.
  - Inputs: clk, rst, clear, in_valid, in_score, in_class.
  - Outputs: best_score, best_class, best_valid.
  - The FSM/address counter stays in the top module.

Test Plan:
- Scores = class index (0..25); start pulse → inf_valid at start+28 cycles, inference=25, inf_score=25.
- Class 25 = 8191, others 100 → inference=25, inf_score=8191; class 0 = 8191, others 8190 → inference=0.
- Classes 3 and 17 = 5000, others ≤4999 → inference=3 (lowest-index tie); all scores 0 → inference=0, inf_score=0.
- Backpressure: inf_ready low for 10 cycles after inf_valid → valid, inference and score held stable for all 10 cycles; ready high → inf_valid=0 and busy=0 next cycle.
- start re-pulsed at cycle 5 of a scan → no address restart and exactly 26 reads; back-to-back with start and ready held high → results every 29 cycles.
- rst asserted in cycle 12 of FETCH → next cycle all outputs 0 and state IDLE; a new scan of known data then returns the correct argmax with no leftover best from the aborted scan.
